rv_multicycle_ctrl: RTL and testbench

Multi-cycle sequencing FSM for the RV32I core. It replaces per-opcode static decode with a state machine that drives PC, IR, register-file, ALU-mux and shared-memory controls across FETCH/DECODE/EXEC/MEM/WB cycles over a single instruction/data memory port with a ready handshake. Adds memory-timeout and illegal-opcode trapping, plus a retire pulse for performance counting.

---
 rtl/rv_pkg.sv | 64 ++++++
 rtl/rv_multicycle_ctrl_if.sv | 43 ++++
 rtl/rv_wait_timer.sv | 46 ++++
 rtl/rv_multicycle_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_rv_multicycle_ctrl.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared definitions for the RV32I multi-cycle controller.
// Contents:
//   - RV32I base opcodes (IR[6:0])
//   - ALU operation class, PC source, write-back source and ALU operand mux encodings
//   - Controller state encoding (also visible on state_o) and trap causes
//   - is_known_opcode(): true for every opcode the controller can sequence
package rv_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_IARITH = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JALR   = 2'd2;  // ALU result with bit 0 cleared

    localparam logic [1:0] WB_ALUOUT = 2'd0;
    localparam logic [1:0] WB_MDR    = 2'd1;
    localparam logic [1:0] WB_PC     = 2'd2;      // PC register already holds PC+4

    localparam logic [1:0] ALU_A_PC    = 2'd0;
    localparam logic [1:0] ALU_A_OLDPC = 2'd1;
    localparam logic [1:0] ALU_A_RS1   = 2'd2;
    localparam logic [1:0] ALU_A_ZERO  = 2'd3;

    localparam logic [1:0] ALU_B_RS2  = 2'd0;
    localparam logic [1:0] ALU_B_FOUR = 2'd1;
    localparam logic [1:0] ALU_B_IMM  = 2'd2;

    typedef enum logic [1:0] {
        TRAP_NONE    = 2'd0,
        TRAP_ILLEGAL = 2'd1,
        TRAP_TIMEOUT = 2'd2
    } trap_cause_e;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_e;

    function automatic logic is_known_opcode(input logic [6:0] opc);
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
            OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP: return 1'b1;
            default:                                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rv_multicycle_ctrl_if.sv
// Control/handshake bundle between the multi-cycle controller and the datapath.
// master modport = controller side, slave modport = datapath/memory side.
// Handshake: mem_req_o is held high until the cycle in which mem_ready_i is
// sampled high; that cycle completes the transfer, and mem_ready_i has no
// meaning while mem_req_o is low.
//   inputs to master : opcode_i, mem_ready_i, zero_i
//   outputs of master: PC/IR/register-file strobes, ALU mux selects, memory
//                      request, retire pulse, trap status, debug state
interface rv_multicycle_ctrl_if;
    logic [6:0] opcode_i;
    logic       mem_ready_i;
    logic       zero_i;
    logic       pc_write_o;
    logic       pc_write_cond_o;
    logic [1:0] pc_src_o;
    logic       ir_write_o;
    logic       mem_req_o;
    logic       mem_we_o;
    logic       iord_o;
    logic       reg_write_o;
    logic [1:0] wb_sel_o;
    logic [1:0] alu_src_a_o;
    logic [1:0] alu_src_b_o;
    logic [1:0] alu_op_o;
    logic       retire_o;
    logic       trap_o;
    logic [1:0] trap_cause_o;
    logic [2:0] state_o;

    modport master (
        input  opcode_i, mem_ready_i, zero_i,
        output pc_write_o, pc_write_cond_o, pc_src_o, ir_write_o, mem_req_o,
               mem_we_o, iord_o, reg_write_o, wb_sel_o, alu_src_a_o,
               alu_src_b_o, alu_op_o, retire_o, trap_o, trap_cause_o, state_o
    );

    modport slave (
        output opcode_i, mem_ready_i, zero_i,
        input  pc_write_o, pc_write_cond_o, pc_src_o, ir_write_o, mem_req_o,
               mem_we_o, iord_o, reg_write_o, wb_sel_o, alu_src_a_o,
               alu_src_b_o, alu_op_o, retire_o, trap_o, trap_cause_o, state_o
    );
endinterface

// File: rtl/rv_wait_timer.sv
// Memory wait-cycle counter.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   clr_i        : return count to zero (has priority over en_i)
//   en_i         : count one more waiting cycle
//   expired_o    : the current waiting cycle is the MEM_TIMEOUT-th one
// With MEM_TIMEOUT == 0 the counter never advances and never expires.
module rv_wait_timer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TIMER_W     = 5
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    logic [TIMER_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (MEM_TIMEOUT != 0)) begin
            count_d = count_q + TIMER_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // count_q holds the number of waiting cycles already completed, so the
    // MEM_TIMEOUT-th waiting cycle is the one where it equals MEM_TIMEOUT-1.
    generate
        if (MEM_TIMEOUT == 0) begin : g_no_timeout
            assign expired_o = 1'b0;
        end else begin : g_timeout
            assign expired_o = (count_q == TIMER_W'(MEM_TIMEOUT - 1));
        end
    endgenerate
endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle sequencing FSM for the RV32I core: FETCH/DECODE/EXEC/MEM/WB
// over one shared instruction/data memory port, with memory-timeout and
// illegal-opcode traps and a retire pulse per completed instruction.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   bus (master) : opcode/mem_ready/zero in; PC, IR, register-file, ALU-mux,
//                  memory, retire, trap and debug-state outputs
module rv_multicycle_ctrl
    import rv_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TIMER_W     = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    rv_multicycle_ctrl_if.master bus
);
    state_e      state_q, state_d;
    trap_cause_e trap_cause_q, trap_cause_d;
    logic        trap_q;
    logic        wait_en, timer_expired;

    logic       pc_write, pc_write_cond, ir_write, mem_req, mem_we, iord;
    logic       reg_write, retire;
    logic [1:0] pc_src, wb_sel, alu_a, alu_b, alu_op;

    // Counter runs only while a request is outstanding, so it is already zero
    // on entry to FETCH or MEM.
    rv_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT), .TIMER_W(TIMER_W)) u_wait_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (!wait_en),
        .en_i      (wait_en),
        .expired_o (timer_expired)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_FETCH;
            trap_q       <= 1'b0;
            trap_cause_q <= TRAP_NONE;
        end else begin
            state_q      <= state_d;
            trap_q       <= (state_d == S_TRAP);
            trap_cause_q <= trap_cause_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        trap_cause_d  = trap_cause_q;
        wait_en       = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = PC_SRC_ALU;
        ir_write      = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        iord          = 1'b0;
        reg_write     = 1'b0;
        wb_sel        = WB_ALUOUT;
        alu_a         = ALU_A_PC;
        alu_b         = ALU_B_RS2;
        alu_op        = ALUOP_ADD;
        retire        = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                alu_b   = ALU_B_FOUR;       // PC + 4 computed alongside the fetch
                // A response in the limit cycle still wins over the timeout.
                if (bus.mem_ready_i) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (timer_expired) begin
                    state_d      = S_TRAP;
                    trap_cause_d = TRAP_TIMEOUT;
                end else begin
                    wait_en = 1'b1;
                end
            end
            S_DECODE: begin
                alu_a = ALU_A_OLDPC;        // speculative branch/JAL target
                alu_b = ALU_B_IMM;
                if (is_known_opcode(bus.opcode_i)) begin
                    state_d = S_EXEC;
                end else begin
                    state_d      = S_TRAP;
                    trap_cause_d = TRAP_ILLEGAL;
                end
            end
            S_EXEC: begin
                case (bus.opcode_i)
                    OPC_OP: begin
                        alu_a = ALU_A_RS1; alu_b = ALU_B_RS2; alu_op = ALUOP_RTYPE;
                        state_d = S_WB;
                    end
                    OPC_OP_IMM: begin
                        alu_a = ALU_A_RS1; alu_b = ALU_B_IMM; alu_op = ALUOP_IARITH;
                        state_d = S_WB;
                    end
                    OPC_LUI: begin
                        alu_a = ALU_A_ZERO; alu_b = ALU_B_IMM;
                        state_d = S_WB;
                    end
                    OPC_AUIPC: begin
                        alu_a = ALU_A_OLDPC; alu_b = ALU_B_IMM;
                        state_d = S_WB;
                    end
                    OPC_LOAD, OPC_STORE: begin
                        alu_a = ALU_A_RS1; alu_b = ALU_B_IMM;
                        state_d = S_MEM;
                    end
                    OPC_BRANCH: begin
                        alu_a = ALU_A_RS1; alu_b = ALU_B_RS2; alu_op = ALUOP_BRANCH;
                        pc_write_cond = 1'b1;
                        pc_src        = PC_SRC_ALUOUT;
                        retire        = 1'b1;
                        state_d       = S_FETCH;
                    end
                    OPC_JAL: begin
                        // Link (PC reg, already PC+4) and jump share this edge.
                        pc_write  = 1'b1;
                        pc_src    = PC_SRC_ALUOUT;
                        reg_write = 1'b1;
                        wb_sel    = WB_PC;
                        retire    = 1'b1;
                        state_d   = S_FETCH;
                    end
                    OPC_JALR: begin
                        alu_a = ALU_A_RS1; alu_b = ALU_B_IMM;
                        pc_write  = 1'b1;
                        pc_src    = PC_SRC_JALR;
                        reg_write = 1'b1;
                        wb_sel    = WB_PC;
                        retire    = 1'b1;
                        state_d   = S_FETCH;
                    end
                    default: begin
                        // IR is stable after DECODE; only reachable on corruption.
                        state_d      = S_TRAP;
                        trap_cause_d = TRAP_ILLEGAL;
                    end
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = (bus.opcode_i == OPC_STORE);
                if (bus.mem_ready_i) begin
                    if (bus.opcode_i == OPC_STORE) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timer_expired) begin
                    state_d      = S_TRAP;
                    trap_cause_d = TRAP_TIMEOUT;
                end else begin
                    wait_en = 1'b1;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                wb_sel    = (bus.opcode_i == OPC_LOAD) ? WB_MDR : WB_ALUOUT;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;           // held until reset
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Reset forces state to FETCH asynchronously; keep the request and
        // every write strobe low while reset is held so nothing is issued.
        if (rst_i) begin
            mem_req       = 1'b0;
            mem_we        = 1'b0;
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            reg_write     = 1'b0;
            retire        = 1'b0;
        end
    end

    assign bus.pc_write_o      = pc_write;
    assign bus.pc_write_cond_o = pc_write_cond;
    assign bus.pc_src_o        = pc_src;
    assign bus.ir_write_o      = ir_write;
    assign bus.mem_req_o       = mem_req;
    assign bus.mem_we_o        = mem_we;
    assign bus.iord_o          = iord;
    assign bus.reg_write_o     = reg_write;
    assign bus.wb_sel_o        = wb_sel;
    assign bus.alu_src_a_o     = alu_a;
    assign bus.alu_src_b_o     = alu_b;
    assign bus.alu_op_o        = alu_op;
    assign bus.retire_o        = retire;
    assign bus.trap_o          = trap_q;
    assign bus.trap_cause_o    = trap_cause_q;
    assign bus.state_o         = state_q;
endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Bench for rv_multicycle_ctrl (MEM_TIMEOUT=4). Each driven cycle pushes the
// hand-written expected output vector; a negedge monitor pops and compares.
// Vector layout: {state, req, we, iord, irw, pcw, pcwc, pcs, rw, wbs, a, b, op, ret, trap, cause}
module tb_rv_multicycle_ctrl;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    rv_multicycle_ctrl_if bus();

    rv_multicycle_ctrl #(.MEM_TIMEOUT(4), .TIMER_W(5)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_AUI = 7'b0010111;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JR  = 7'b1100111;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    logic [23:0] exp_q[$];
    string       name_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic logic [23:0] mk(int st, int req, int we, int iord, int irw,
                                       int pcw, int pcwc, int pcs, int rw, int wbs,
                                       int a, int b, int op, int ret, int trap, int cause);
        return {3'(st), 1'(req), 1'(we), 1'(iord), 1'(irw), 1'(pcw), 1'(pcwc),
                2'(pcs), 1'(rw), 2'(wbs), 2'(a), 2'(b), 2'(op), 1'(ret), 1'(trap), 2'(cause)};
    endfunction

    //                 st req we io irw pcw pcwc pcs rw wbs a  b  op ret trp cs
    logic [23:0] v_rst, v_fw, v_fr, v_dec, v_e_op, v_e_opi, v_e_lui, v_e_aui;
    logic [23:0] v_e_ls, v_e_br, v_e_jal, v_e_jalr, v_wb_a, v_wb_l;
    logic [23:0] v_m_ld, v_m_st, v_m_str, v_t_ill, v_t_to;

    initial begin
        v_rst    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        v_fw     = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        v_fr     = mk(0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        v_dec    = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0);
        v_e_op   = mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0);
        v_e_opi  = mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2, 3, 0, 0, 0);
        v_e_lui  = mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 2, 0, 0, 0, 0);
        v_e_aui  = mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0);
        v_e_ls   = mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2, 0, 0, 0, 0);
        v_e_br   = mk(2, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2, 0, 1, 1, 0, 0);
        v_e_jal  = mk(2, 0, 0, 0, 0, 1, 0, 1, 1, 2, 0, 0, 0, 1, 0, 0);
        v_e_jalr = mk(2, 0, 0, 0, 0, 1, 0, 2, 1, 2, 2, 2, 0, 1, 0, 0);
        v_wb_a   = mk(4, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
        v_wb_l   = mk(4, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0);
        v_m_ld   = mk(3, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v_m_st   = mk(3, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v_m_str  = mk(3, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        v_t_ill  = mk(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        v_t_to   = mk(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
    end

    // Driver: one clock cycle of inputs plus the outputs expected in it.
    task automatic cyc(input logic rst, input logic [6:0] opc, input logic rdy,
                       input logic z, input logic [23:0] v, input string nm);
        @(posedge clk_i);
        #1;
        rst_i           = rst;
        bus.opcode_i    = opc;
        bus.mem_ready_i = rdy;
        bus.zero_i      = z;
        exp_q.push_back(v);
        name_q.push_back(nm);
    endtask

    // Zero-wait fetch + decode, then the given EXEC vector.
    task automatic head(input logic [6:0] opc, input logic z, input logic [23:0] e,
                        input string nm);
        cyc(0, opc, 1, z, v_fr, {nm, "_fetch"});
        cyc(0, opc, 0, z, v_dec, {nm, "_decode"});
        cyc(0, opc, 0, z, e, {nm, "_exec"});
    endtask

    // Monitor
    always @(negedge clk_i) begin
        logic [23:0] got, e;
        string nm;
        if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            got = {bus.state_o, bus.mem_req_o, bus.mem_we_o, bus.iord_o, bus.ir_write_o,
                   bus.pc_write_o, bus.pc_write_cond_o, bus.pc_src_o, bus.reg_write_o,
                   bus.wb_sel_o, bus.alu_src_a_o, bus.alu_src_b_o, bus.alu_op_o,
                   bus.retire_o, bus.trap_o, bus.trap_cause_o};
            n_cmp++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, e, $time);
            end
        end
    end

    initial begin
        bus.opcode_i    = OP_R;
        bus.mem_ready_i = 1'b0;
        bus.zero_i      = 1'b0;

        cyc(1, OP_R, 0, 0, v_rst, "reset_0");
        cyc(1, OP_R, 1, 0, v_rst, "reset_1");

        head(OP_R, 0, v_e_op, "op");      cyc(0, OP_R, 0, 0, v_wb_a, "op_wb");
        head(OP_I, 0, v_e_opi, "opimm");  cyc(0, OP_I, 0, 0, v_wb_a, "opimm_wb");
        head(OP_LUI, 0, v_e_lui, "lui");  cyc(0, OP_LUI, 0, 0, v_wb_a, "lui_wb");
        head(OP_AUI, 0, v_e_aui, "auipc"); cyc(0, OP_AUI, 0, 0, v_wb_a, "auipc_wb");
        head(OP_JAL, 0, v_e_jal, "jal");
        head(OP_JR, 0, v_e_jalr, "jalr");
        head(OP_BR, 1, v_e_br, "br_taken");
        head(OP_BR, 0, v_e_br, "br_not_taken");

        // LOAD with three wait cycles; the response lands in the 4th cycle,
        // exactly when the timeout limit is reached, and must win.
        head(OP_LD, 0, v_e_ls, "load");
        for (int i = 0; i < 3; i++) cyc(0, OP_LD, 0, 0, v_m_ld, "load_mem_wait");
        cyc(0, OP_LD, 1, 0, v_m_ld, "load_mem_done");
        cyc(0, OP_LD, 0, 0, v_wb_l, "load_wb");

        head(OP_ST, 0, v_e_ls, "store");
        cyc(0, OP_ST, 1, 0, v_m_str, "store_mem_done");

        // Fetch response on the 4th waiting cycle: no trap.
        for (int i = 0; i < 3; i++) cyc(0, OP_R, 0, 0, v_fw, "fetch_wait");
        cyc(0, OP_R, 1, 0, v_fr, "fetch_ready_at_limit");
        cyc(0, OP_R, 0, 0, v_dec, "late_op_decode");
        cyc(0, OP_R, 0, 0, v_e_op, "late_op_exec");
        cyc(0, OP_R, 0, 0, v_wb_a, "late_op_wb");

        // Reset in the middle of a stalled store.
        head(OP_ST, 0, v_e_ls, "store2");
        cyc(0, OP_ST, 0, 0, v_m_st, "store2_mem_wait0");
        cyc(0, OP_ST, 0, 0, v_m_st, "store2_mem_wait1");
        cyc(1, OP_ST, 0, 0, v_rst, "reset_mid_store");
        cyc(0, OP_BAD, 0, 0, v_fw, "post_reset_fetch");

        // Illegal opcode: trap after DECODE, memory ignored.
        cyc(0, OP_BAD, 1, 0, v_fr, "bad_fetch");
        cyc(0, OP_BAD, 0, 0, v_dec, "bad_decode");
        for (int i = 0; i < 20; i++) cyc(0, OP_BAD, 1'(i & 1), 0, v_t_ill, "illegal_trap_hold");

        cyc(1, OP_R, 0, 0, v_rst, "reset_after_trap");

        // Fetch timeout: 4 waiting cycles, then TRAP with cause 2.
        for (int i = 0; i < 4; i++) cyc(0, OP_R, 0, 0, v_fw, "timeout_fetch_wait");
        for (int i = 0; i < 3; i++) cyc(0, OP_R, 1, 0, v_t_to, "timeout_trap");

        @(negedge clk_i);
        #1;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
